// File: rtl/module_switch_debounce_pkg.sv
// -----------------------------------------------------------------------------
// module_switch_debounce_pkg
// Shared debounce constants for the slide-switch conditioning stage.
//   CLK_FREQ_HZ           : board clock frequency
//   DEBOUNCE_MS           : required quiet time before a switch level is trusted
//   DEFAULT_STABLE_CYCLES : quiet time expressed in clock cycles
//   cnt_width()           : width of a per-bit debounce counter
// -----------------------------------------------------------------------------
package module_switch_debounce_pkg;

    localparam int CLK_FREQ_HZ           = 32'd27000000;
    localparam int DEBOUNCE_MS           = 32'd10;
    localparam int CYCLES_PER_MS         = CLK_FREQ_HZ / 32'd1000;
    localparam int DEFAULT_STABLE_CYCLES = CYCLES_PER_MS * DEBOUNCE_MS;

    // The counter only has to reach STABLE_CYCLES-1, so $clog2 of the cycle
    // count is enough; never return less than one bit.
    function automatic int cnt_width(input int stable_cycles);
        int w;
        w = $clog2(stable_cycles);
        if (w < 32'sd1) begin
            w = 32'sd1;
        end
        return w;
    endfunction

endpackage : module_switch_debounce_pkg

// File: rtl/module_debounce_bit.sv
// -----------------------------------------------------------------------------
// module_debounce_bit
// Synchroniser, debounce counter and output flop for one switch bit.
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset, clears every flop
//   sw_i   : raw asynchronous switch level
//   bit_o  : debounced level (registered)
//   edge_o : one-cycle pulse while bit_o holds a freshly updated value
// -----------------------------------------------------------------------------
module module_debounce_bit
    import module_switch_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic bit_o,
    output logic edge_o
);

    localparam int             CW       = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  TERMINAL = CW'(STABLE_CYCLES - 32'sd1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(32'd0);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);

    logic          s1_r;
    logic          s2_r;
    logic          bit_r;
    logic          edge_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchroniser, qualification counter and output/strobe flops.
    // The counter only runs while the synchronised level disagrees with the
    // debounced level, so it can never pass TERMINAL and never wraps.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_r   <= 1'b0;
            s2_r   <= 1'b0;
            bit_r  <= 1'b0;
            edge_r <= 1'b0;
            cnt_r  <= CNT_ZERO;
        end else begin
            s1_r   <= sw_i;
            s2_r   <= s1_r;
            edge_r <= 1'b0;
            if (s2_r != bit_r) begin
                if (cnt_r == TERMINAL) begin
                    bit_r  <= s2_r;
                    edge_r <= 1'b1;
                    cnt_r  <= CNT_ZERO;
                end else begin
                    cnt_r  <= cnt_r + CNT_ONE;
                end
            end else begin
                // Any return to the debounced level restarts qualification.
                cnt_r <= CNT_ZERO;
            end
        end
    end

    assign bit_o  = bit_r;
    assign edge_o = edge_r;

endmodule : module_debounce_bit

// File: rtl/module_switch_debounce.sv
// -----------------------------------------------------------------------------
// module_switch_debounce
// Synchronises and debounces WIDTH slide-switch bits independently and
// presents a clean registered word with update strobes.
//   clk_i     : system clock (27 MHz on board)
//   rst_i     : synchronous active-high reset
//   sw_i      : raw asynchronous switch levels
//   sw_o      : debounced switch word
//   changed_o : one-cycle pulse on the cycle sw_o takes a new value
//   edge_o    : per-bit one-cycle pulse marking which bits changed
// -----------------------------------------------------------------------------
module module_switch_debounce
    import module_switch_debounce_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic             changed_o,
    output logic [WIDTH-1:0] edge_o
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            module_debounce_bit #(
                .STABLE_CYCLES(STABLE_CYCLES)
            ) u_bit (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .sw_i  (sw_i[gi]),
                .bit_o (sw_o[gi]),
                .edge_o(edge_o[gi])
            );
        end
    endgenerate

    // OR of registered strobes: one pulse even when several bits settle together.
    assign changed_o = |edge_o;

endmodule : module_switch_debounce

// File: doc/module_switch_debounce.md
Name: module_switch_debounce

Overview:
- Upstream conditioning stage for the board's slide switches. It sits between the raw switch pins and the Gray-code input decoder.
- Each bit is synchronised into the clock domain and debounced independently.
- The block presents a clean registered word plus a one-cycle update strobe, so the decoder and display chain never see metastable or bouncing values.

Parameters:
- WIDTH, 4, number of switch bits handled.
- STABLE_CYCLES, 270000, consecutive clock cycles a synchronised bit must differ from its debounced value before the output takes the new value. The default is 10 ms at 27 MHz. Legal range is 2 to 2^24.

Ports:
- clk_i  input  1  system clock (27 MHz on board).
- rst_i  input  1  synchronous, active-high reset.
- sw_i  input  WIDTH  raw asynchronous switch levels.
- sw_o  output  WIDTH  debounced switch word.
- changed_o  output  1  one-cycle pulse on the cycle sw_o takes a new value.
- edge_o  output  WIDTH  per-bit one-cycle pulse marking which bits changed in that update.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All flops, including the synchroniser flops, clear on a clk_i edge with rst_i=1.
- Reset values: sw_o=0, changed_o=0, edge_o=0, all counters 0, synchroniser stages 0.
- Synchroniser: two-flop chain per bit, sw_i -> s1 -> s2. There is no combinational path from sw_i to any output.
- Per-bit debounce counter: width $clog2(STABLE_CYCLES).
  - If s2[b] == sw_o[b]: counter[b] clears to 0.
  - If s2[b] != sw_o[b] and counter[b] < STABLE_CYCLES-1: counter[b] increments.
  - If s2[b] != sw_o[b] and counter[b] == STABLE_CYCLES-1: on that edge sw_o[b] <= s2[b], counter[b] <= 0, edge_o[b] <= 1.
- Latency: a clean level change on sw_i[b] appears on sw_o[b] exactly STABLE_CYCLES+2 rising edges after the first edge that samples it.
- Bounce rejection: any return of s2[b] to sw_o[b] before the terminal count restarts the count from 0. A glitch shorter than STABLE_CYCLES never reaches sw_o.
- Counter bound: counters never wrap. The terminal count is reached only while s2 differs from sw_o, and is followed by a clear.
- Strobes:
  - edge_o[b] is high for exactly the one cycle in which sw_o[b] holds its newly updated value. It is registered together with sw_o.
  - changed_o = OR of the registered edge bits. It is a single pulse even when several bits update on the same edge.
  - Strobes are 0 in every other cycle.
- Independence: bits are fully independent, with no cross-bit gating. Bits that settle on different cycles produce separate pulses.
- Reset mid-count: rst_i=1 on any edge discards all counts and synchroniser contents. sw_o returns to 0 even if the switches are high. After release, high switches are re-qualified over STABLE_CYCLES+2 edges and produce a normal update pulse.
- Simultaneous reset and terminal count: reset wins. No pulse is produced.

Decomposition:
- Shared package (debounce constants):
  - CLK_FREQ_HZ = 27000000.
  - DEBOUNCE_MS = 10.
  - Derived default STABLE_CYCLES.
  - Counter-width function.
- One natural sub-module: module_debounce_bit.
  - Contents: synchroniser, counter and output flop for a single bit, exposing bit_o and edge_o.
  - The top instantiates WIDTH copies in a generate loop and ORs edge_o into changed_o.

Test Plan (all scenarios run with STABLE_CYCLES=8):
- Reset: hold rst_i=1 with sw_i=4'hF -> sw_o=0, changed_o=0, edge_o=0 for every cycle of reset. After release, sw_o=4'hF exactly 10 edges later, with changed_o=1 and edge_o=4'hF for one cycle.
- Clean step: sw_i 4'h0 -> 4'h5 held -> sw_o=4'h5 on edge 10 after the change, edge_o=4'h5, single changed_o pulse. Then sw_i back to 4'h0 -> sw_o=4'h0 after 10 edges, edge_o=4'h5.
- Bounce: bit0 toggles high for 3 cycles, low for 2, high for 5, low -> sw_o stays 4'h0 and changed_o never asserts. Bit0 then held high -> update 10 edges after the final rising transition.
- Staggered bits: bit1 rises at cycle 0 and bit3 rises at cycle 4 -> two separate changed_o pulses 4 cycles apart, with edge_o=4'h2 then 4'h8, and final sw_o=4'hA.
- Reset mid-count: sw_i=4'h1, assert rst_i at count 5 for one cycle, release with sw_i still 4'h1 -> no pulse before reset. sw_o=4'h1 exactly 10 edges after release.
- Simultaneous edge: all bits change on the same cycle -> exactly one changed_o pulse and edge_o=4'hF. Verify no pulse in the next cycle.
